// File: rtl/pong_if.sv
// Referee-facing bus: frame timing, match control, object geometry in; events and score state out.
// The game side drives it through master; the referee sits on slave.
interface pong_if #(
    parameter int POS_W   = 10,
    parameter int SIZE_W  = 8,
    parameter int SCORE_W = 4
);
    logic               frame_tick;
    logic               start;
    logic [POS_W-1:0]   ball_pos_x, ball_pos_y;
    logic [POS_W-1:0]   paddle_1_pos_x, paddle_1_pos_y;
    logic [POS_W-1:0]   paddle_2_pos_x, paddle_2_pos_y;
    logic [SIZE_W-1:0]  ball_size_x, ball_size_y;
    logic [SIZE_W-1:0]  paddle_1_size_x, paddle_1_size_y;
    logic [SIZE_W-1:0]  paddle_2_size_x, paddle_2_size_y;
    logic [1:0]         bounce;
    logic [SCORE_W-1:0] score_player_1, score_player_2;
    logic               serve_dir;
    logic               game_over;
    logic [1:0]         winner;

    modport master (
        output frame_tick, start,
        output ball_pos_x, ball_pos_y, paddle_1_pos_x, paddle_1_pos_y,
        output paddle_2_pos_x, paddle_2_pos_y,
        output ball_size_x, ball_size_y, paddle_1_size_x, paddle_1_size_y,
        output paddle_2_size_x, paddle_2_size_y,
        input  bounce, score_player_1, score_player_2, serve_dir, game_over, winner
    );

    modport slave (
        input  frame_tick, start,
        input  ball_pos_x, ball_pos_y, paddle_1_pos_x, paddle_1_pos_y,
        input  paddle_2_pos_x, paddle_2_pos_y,
        input  ball_size_x, ball_size_y, paddle_1_size_x, paddle_1_size_y,
        input  paddle_2_size_x, paddle_2_size_y,
        output bounce, score_player_1, score_player_2, serve_dir, game_over, winner
    );
endinterface

// File: rtl/pong_referee.sv
// Pong match referee: serve timing, goal/wall/paddle detection, scoring and win detection.
// Everything advances only on frame_tick; outputs are all registered.
module pong_referee #(
    parameter int SCREEN_X     = 640,
    parameter int SCREEN_Y     = 480,
    parameter int MARGIN       = 5,
    parameter int POS_W        = 10,
    parameter int SIZE_W       = 8,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input logic  clock,
    input logic  reset_n,
    pong_if.slave bus
);
    // One extra bit so position+size never wraps.
    localparam int W     = POS_W + 1;
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [W-1:0]       RGOAL = W'(SCREEN_X - MARGIN);
    localparam logic [W-1:0]       BWALL = W'(SCREEN_Y - MARGIN);
    localparam logic [W-1:0]       MARG  = W'(MARGIN);
    localparam logic [SCORE_W-1:0] WIN   = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SLAST = CNT_W'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, SERVE, PLAY, GAMEOVER} state_t;

    state_t           state;
    logic [CNT_W-1:0] serve_cnt;
    logic             wall_lat, p1_lat, p2_lat;

    logic [W-1:0] ball_r, ball_b, ball_cy, p1_r, p1_b, p2_b;
    logic         goal_r, goal_l, wall, hit_p1, hit_p2;
    logic [SCORE_W-1:0] s1_nxt, s2_nxt;

    always_comb begin
        ball_r  = W'(bus.ball_pos_x) + W'(bus.ball_size_x);
        ball_b  = W'(bus.ball_pos_y) + W'(bus.ball_size_y);
        ball_cy = W'(bus.ball_pos_y) + W'(bus.ball_size_y >> 1);
        p1_r    = W'(bus.paddle_1_pos_x) + W'(bus.paddle_1_size_x);
        p1_b    = W'(bus.paddle_1_pos_y) + W'(bus.paddle_1_size_y);
        p2_b    = W'(bus.paddle_2_pos_y) + W'(bus.paddle_2_size_y);
        goal_r  = ball_r >= RGOAL;
        goal_l  = W'(bus.ball_pos_x) <= MARG;
        wall    = (ball_b >= BWALL) || (W'(bus.ball_pos_y) <= MARG);
        hit_p1  = (W'(bus.ball_pos_x) <= p1_r) &&
                  (ball_cy >= W'(bus.paddle_1_pos_y)) && (ball_cy <= p1_b);
        hit_p2  = (ball_r >= W'(bus.paddle_2_pos_x)) &&
                  (ball_cy >= W'(bus.paddle_2_pos_y)) && (ball_cy <= p2_b);
        s1_nxt  = bus.score_player_1 + SCORE_W'(1);
        s2_nxt  = bus.score_player_2 + SCORE_W'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            serve_cnt          <= '0;
            wall_lat           <= 1'b0;
            p1_lat             <= 1'b0;
            p2_lat             <= 1'b0;
            bus.bounce         <= 2'd0;
            bus.score_player_1 <= '0;
            bus.score_player_2 <= '0;
            bus.serve_dir      <= 1'b1;
            bus.game_over      <= 1'b0;
            bus.winner         <= 2'd0;
        end else begin
            bus.bounce <= 2'd0;
            if (bus.frame_tick) begin
                case (state)
                    IDLE, GAMEOVER: if (bus.start) begin
                        state              <= SERVE;
                        serve_cnt          <= '0;
                        wall_lat           <= 1'b0;
                        p1_lat             <= 1'b0;
                        p2_lat             <= 1'b0;
                        bus.score_player_1 <= '0;
                        bus.score_player_2 <= '0;
                        bus.serve_dir      <= 1'b1;
                        bus.game_over      <= 1'b0;
                        bus.winner         <= 2'd0;
                    end
                    SERVE: begin
                        if (serve_cnt == SLAST) begin
                            serve_cnt  <= '0;
                            bus.bounce <= 2'd3;
                            state      <= PLAY;
                        end else begin
                            serve_cnt <= serve_cnt + CNT_W'(1);
                        end
                    end
                    PLAY: begin
                        // Latches track this tick's contact so only the leading tick emits.
                        wall_lat <= wall;
                        p1_lat   <= hit_p1;
                        p2_lat   <= hit_p2;
                        if (goal_r) begin
                            bus.score_player_1 <= s1_nxt;
                            bus.serve_dir      <= 1'b1;
                            wall_lat <= 1'b0; p1_lat <= 1'b0; p2_lat <= 1'b0;
                            if (s1_nxt == WIN) begin
                                state         <= GAMEOVER;
                                bus.game_over <= 1'b1;
                                bus.winner    <= 2'd1;
                            end else begin
                                state <= SERVE;
                            end
                        end else if (goal_l) begin
                            bus.score_player_2 <= s2_nxt;
                            bus.serve_dir      <= 1'b0;
                            wall_lat <= 1'b0; p1_lat <= 1'b0; p2_lat <= 1'b0;
                            if (s2_nxt == WIN) begin
                                state         <= GAMEOVER;
                                bus.game_over <= 1'b1;
                                bus.winner    <= 2'd2;
                            end else begin
                                state <= SERVE;
                            end
                        end else if (wall && !wall_lat) begin
                            bus.bounce <= 2'd2;
                        end else if ((hit_p1 && !p1_lat) || (hit_p2 && !p2_lat)) begin
                            bus.bounce <= 2'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pong_referee.sv
// Directed bench for pong_referee: dut_a uses default WIN_SCORE, dut_b WIN_SCORE=2; both SERVE_FRAMES=2.
module tb_pong_referee;
    logic clock, reset_n;
    int checks = 0;
    int failures = 0;

    pong_if #(.POS_W(10), .SIZE_W(8), .SCORE_W(4)) ifa ();
    pong_if #(.POS_W(10), .SIZE_W(8), .SCORE_W(4)) ifb ();

    pong_referee #(.SERVE_FRAMES(2)) dut_a (.clock(clock), .reset_n(reset_n), .bus(ifa));
    pong_referee #(.SERVE_FRAMES(2), .WIN_SCORE(2)) dut_b (.clock(clock), .reset_n(reset_n), .bus(ifb));

    assign ifb.frame_tick      = ifa.frame_tick;
    assign ifb.start           = ifa.start;
    assign ifb.ball_pos_x      = ifa.ball_pos_x;
    assign ifb.ball_pos_y      = ifa.ball_pos_y;
    assign ifb.ball_size_x     = ifa.ball_size_x;
    assign ifb.ball_size_y     = ifa.ball_size_y;
    assign ifb.paddle_1_pos_x  = ifa.paddle_1_pos_x;
    assign ifb.paddle_1_pos_y  = ifa.paddle_1_pos_y;
    assign ifb.paddle_1_size_x = ifa.paddle_1_size_x;
    assign ifb.paddle_1_size_y = ifa.paddle_1_size_y;
    assign ifb.paddle_2_pos_x  = ifa.paddle_2_pos_x;
    assign ifb.paddle_2_pos_y  = ifa.paddle_2_pos_y;
    assign ifb.paddle_2_size_x = ifa.paddle_2_size_x;
    assign ifb.paddle_2_size_y = ifa.paddle_2_size_y;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic do_tick();
        @(negedge clock);
        ifa.frame_tick = 1'b1;
        @(posedge clock);
        #1;
        ifa.frame_tick = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic neutral();
        ifa.ball_pos_x = 10'd300;
        ifa.ball_pos_y = 10'd200;
        ifa.ball_size_x = 8'd8;
        ifa.ball_size_y = 8'd8;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        ifa.start = 1'b0;
        ifa.frame_tick = 1'b0;
        neutral();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // start tick plus two serve ticks: leaves both DUTs in PLAY
    task automatic start_match();
        ifa.start = 1'b1;
        do_tick();
        ifa.start = 1'b0;
        do_tick();
        do_tick();
    endtask

    task automatic goal_and_serve(input logic [9:0] x);
        ifa.ball_pos_x = x;
        do_tick();
        neutral();
        do_tick();
        do_tick();
    endtask

    task automatic test_reset();
        logic [13:0] got;
        do_reset();
        got = {ifa.bounce, ifa.score_player_1, ifa.score_player_2, ifa.serve_dir, ifa.game_over, ifa.winner};
        checks++;
        if (got !== 14'b00_0000_0000_1_0_00) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", got, 14'b00_0000_0000_1_0_00);
        end
    endtask

    task automatic test_reset_midplay();
        logic [13:0] got;
        do_reset();
        start_match();
        goal_and_serve(10'd630);
        goal_and_serve(10'd630);
        goal_and_serve(10'd630);
        goal_and_serve(10'd3);
        goal_and_serve(10'd3);
        checks++;
        if ({ifa.score_player_1, ifa.score_player_2, ifa.serve_dir} !== {4'd3, 4'd2, 1'b0}) begin
            failures++;
            $display("FAIL score_3_2 got=%0d:%0d dir=%0d exp=3:2 dir=0",
                     ifa.score_player_1, ifa.score_player_2, ifa.serve_dir);
        end
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        got = {ifa.bounce, ifa.score_player_1, ifa.score_player_2, ifa.serve_dir, ifa.game_over, ifa.winner};
        checks++;
        if (got !== 14'b00_0000_0000_1_0_00) begin
            failures++;
            $display("FAIL midplay_reset got=%b exp=%b", got, 14'b00_0000_0000_1_0_00);
        end
        @(negedge clock);
        reset_n = 1'b1;
        // back in IDLE: ticks without start must never produce a serve
        for (int i = 0; i < 3; i++) begin
            do_tick();
            checks++;
            if (ifa.bounce !== 2'd0) begin
                failures++;
                $display("FAIL idle_after_reset tick=%0d got=%0d exp=0", i, ifa.bounce);
            end
        end
    endtask

    task automatic test_serve();
        logic [1:0] exp [5] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
        do_reset();
        ifa.start = 1'b1;
        do_tick();
        ifa.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1 || i == 3) do_tick();
            else if (i > 0) idle_cycle();
            checks++;
            if (ifa.bounce !== exp[i]) begin
                failures++;
                $display("FAIL serve_seq step=%0d got=%0d exp=%0d", i, ifa.bounce, exp[i]);
            end
        end
    endtask

    task automatic test_wall();
        logic [9:0] ys  [12] = '{10'd3, 10'd3, 10'd3, 10'd3, 10'd200, 10'd3,
                                 10'd200, 10'd466, 10'd467, 10'd200, 10'd6, 10'd5};
        logic [1:0] exp [12] = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2,
                                 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd2};
        for (int i = 0; i < 12; i++) begin
            ifa.ball_pos_y = ys[i];
            do_tick();
            checks++;
            if (ifa.bounce !== exp[i]) begin
                failures++;
                $display("FAIL wall step=%0d y=%0d got=%0d exp=%0d", i, ys[i], ifa.bounce, exp[i]);
            end
        end
        neutral();
        do_tick();
    endtask

    task automatic test_goal();
        do_reset();
        start_match();
        ifa.ball_pos_x = 10'd626;
        do_tick();
        checks++;
        if ({ifa.score_player_1, ifa.bounce} !== {4'd0, 2'd0}) begin
            failures++;
            $display("FAIL right_goal_edge s1=%0d b=%0d exp s1=0 b=0", ifa.score_player_1, ifa.bounce);
        end
        ifa.ball_pos_x = 10'd627;
        ifa.ball_pos_y = 10'd467;
        do_tick();
        checks++;
        if ({ifa.score_player_1, ifa.serve_dir, ifa.bounce} !== {4'd1, 1'b1, 2'd0}) begin
            failures++;
            $display("FAIL right_goal s1=%0d dir=%0d b=%0d exp s1=1 dir=1 b=0",
                     ifa.score_player_1, ifa.serve_dir, ifa.bounce);
        end
        neutral();
        do_tick();
        checks++;
        if (ifa.bounce !== 2'd0) begin
            failures++;
            $display("FAIL reserve_wait got=%0d exp=0", ifa.bounce);
        end
        do_tick();
        checks++;
        if (ifa.bounce !== 2'd3) begin
            failures++;
            $display("FAIL reserve got=%0d exp=3", ifa.bounce);
        end
        ifa.ball_pos_x = 10'd6;
        do_tick();
        checks++;
        if ({ifa.score_player_2, ifa.bounce} !== {4'd0, 2'd0}) begin
            failures++;
            $display("FAIL left_goal_edge s2=%0d b=%0d exp s2=0 b=0", ifa.score_player_2, ifa.bounce);
        end
        ifa.ball_pos_x = 10'd5;
        do_tick();
        checks++;
        if ({ifa.score_player_1, ifa.score_player_2, ifa.serve_dir} !== {4'd1, 4'd1, 1'b0}) begin
            failures++;
            $display("FAIL left_goal got=%0d:%0d dir=%0d exp=1:1 dir=0",
                     ifa.score_player_1, ifa.score_player_2, ifa.serve_dir);
        end
    endtask

    task automatic test_paddle();
        logic [9:0] xs  [8] = '{10'd615, 10'd615, 10'd300, 10'd615, 10'd300, 10'd19, 10'd18, 10'd300};
        logic [9:0] ys  [8] = '{10'd136, 10'd136, 10'd200, 10'd137, 10'd200, 10'd96, 10'd96, 10'd200};
        logic [1:0] exp [8] = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
        do_reset();
        start_match();
        for (int i = 0; i < 8; i++) begin
            ifa.ball_pos_x = xs[i];
            ifa.ball_pos_y = ys[i];
            do_tick();
            checks++;
            if (ifa.bounce !== exp[i]) begin
                failures++;
                $display("FAIL paddle step=%0d x=%0d y=%0d got=%0d exp=%0d",
                         i, xs[i], ys[i], ifa.bounce, exp[i]);
            end
        end
    endtask

    task automatic test_win();
        do_reset();
        start_match();
        goal_and_serve(10'd5);
        checks++;
        if ({ifb.score_player_2, ifb.game_over} !== {4'd1, 1'b0}) begin
            failures++;
            $display("FAIL win_first s2=%0d go=%0d exp s2=1 go=0", ifb.score_player_2, ifb.game_over);
        end
        ifa.ball_pos_x = 10'd5;
        do_tick();
        checks++;
        if ({ifb.score_player_2, ifb.game_over, ifb.winner} !== {4'd2, 1'b1, 2'd2}) begin
            failures++;
            $display("FAIL win_final s2=%0d go=%0d win=%0d exp s2=2 go=1 win=2",
                     ifb.score_player_2, ifb.game_over, ifb.winner);
        end
        do_tick();
        ifa.ball_pos_x = 10'd630;
        do_tick();
        checks++;
        if ({ifb.score_player_1, ifb.score_player_2, ifb.bounce, ifb.game_over} !== {4'd0, 4'd2, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL win_frozen got=%0d:%0d b=%0d go=%0d exp=0:2 b=0 go=1",
                     ifb.score_player_1, ifb.score_player_2, ifb.bounce, ifb.game_over);
        end
        neutral();
        ifa.start = 1'b1;
        do_tick();
        ifa.start = 1'b0;
        checks++;
        if ({ifb.score_player_1, ifb.score_player_2, ifb.game_over, ifb.winner, ifb.serve_dir} !==
            {4'd0, 4'd0, 1'b0, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL restart got=%0d:%0d go=%0d win=%0d dir=%0d exp=0:0 go=0 win=0 dir=1",
                     ifb.score_player_1, ifb.score_player_2, ifb.game_over, ifb.winner, ifb.serve_dir);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        ifa.frame_tick = 1'b0;
        ifa.start = 1'b0;
        neutral();
        ifa.paddle_1_pos_x = 10'd10;
        ifa.paddle_1_pos_y = 10'd100;
        ifa.paddle_1_size_x = 8'd8;
        ifa.paddle_1_size_y = 8'd40;
        ifa.paddle_2_pos_x = 10'd620;
        ifa.paddle_2_pos_y = 10'd100;
        ifa.paddle_2_size_x = 8'd8;
        ifa.paddle_2_size_y = 8'd40;
        test_reset();
        test_reset_midplay();
        test_serve();
        test_wall();
        test_goal();
        test_paddle();
        test_win();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pong_referee.md
PONG_REFEREE -- requirements
Module: pong_referee

Interface
REQ-001 SHALL have parameter SCREEN_X, default 640, meaning playfield width in pixels.
REQ-002 SHALL have parameter SCREEN_Y, default 480, meaning playfield height in pixels.
REQ-003 SHALL have parameter MARGIN, default 5, meaning goal/wall threshold distance from each screen edge.
REQ-004 SHALL have parameter POS_W, default 10, meaning position bus width.
REQ-005 SHALL have parameter SIZE_W, default 8, meaning size bus width.
REQ-006 SHALL have parameter SCORE_W, default 4, meaning score counter width.
REQ-007 SHALL have parameter WIN_SCORE, default 9, meaning points needed to win; legal range 1..2^SCORE_W-1.
REQ-008 SHALL have parameter SERVE_FRAMES, default 60, meaning frames to wait before each serve; minimum 1.
REQ-009 SHALL have one clock and an asynchronous, active-low reset: clock  in  1  system clock; reset_n  in  1  asynchronous active-low reset.
REQ-010 SHALL have: frame_tick  in  1  one-cycle pulse, once per video frame; all evaluation happens only on ticked cycles.
REQ-011 SHALL have: start  in  1  level; begins a match from IDLE or GAMEOVER.
REQ-012 SHALL have: ball_pos_x, ball_pos_y, paddle_1_pos_x, paddle_1_pos_y, paddle_2_pos_x, paddle_2_pos_y  in  POS_W each  top-left corners.
REQ-013 SHALL have: ball_size_x, ball_size_y, paddle_1_size_x, paddle_1_size_y, paddle_2_size_x, paddle_2_size_y  in  SIZE_W each  extents.
REQ-014 SHALL have: bounce  out  2  registered one-cycle event: 0 none, 1 paddle, 2 wall, 3 serve.
REQ-015 SHALL have: score_player_1, score_player_2  out  SCORE_W each  scores.
REQ-016 SHALL have: serve_dir  out  1  0 = serve towards player 1 (left), 1 = towards player 2 (right).
REQ-017 SHALL have: game_over  out  1  high in GAMEOVER; winner  out  2  0 none, 1 player 1, 2 player 2.

Function
REQ-018 SHALL implement FSM IDLE -> SERVE -> PLAY -> (SERVE | GAMEOVER); GAMEOVER -> SERVE on start.
REQ-019 SHALL, in IDLE or GAMEOVER on a tick with start=1, clear both scores and winner, set serve_dir=1, and enter SERVE.
REQ-020 SHALL, in SERVE, count SERVE_FRAMES ticks, then emit bounce=3 for one cycle and enter PLAY.
REQ-021 SHALL compute all sums at POS_W+1 bits, so no wrap-around occurs; ball centre y = ball_pos_y + floor(ball_size_y/2).
REQ-022 SHALL, in PLAY per tick, evaluate with priority: right goal (ball_pos_x+ball_size_x >= SCREEN_X-MARGIN) > left goal (ball_pos_x <= MARGIN) > wall (ball_pos_y+ball_size_y >= SCREEN_Y-MARGIN or ball_pos_y <= MARGIN) > paddle 1 > paddle 2.
REQ-023 SHALL detect paddle 1 contact when ball_pos_x <= paddle_1_pos_x+paddle_1_size_x and centre y is within [paddle_1_pos_y, paddle_1_pos_y+paddle_1_size_y] inclusive.
REQ-024 SHALL detect paddle 2 contact when ball_pos_x+ball_size_x >= paddle_2_pos_x and centre y is within [paddle_2_pos_y, paddle_2_pos_y+paddle_2_size_y] inclusive.
REQ-025 SHALL emit wall or paddle bounce only on the first tick of a contact; a per-class contact latch suppresses repeats until a tick without that contact.
REQ-026 SHALL, on right goal, increment score_player_1 and set serve_dir=1; on left goal, increment score_player_2 and set serve_dir=0; exactly one increment per goal.
REQ-027 SHALL enter GAMEOVER with winner set when the incremented score equals WIN_SCORE; otherwise re-enter SERVE.
REQ-028 SHALL hold bounce=0 on all non-ticked cycles and in IDLE/GAMEOVER; scores never wrap.
REQ-029 SHALL ignore start while in SERVE or PLAY.

Reset
REQ-030 SHALL, while reset_n=0, immediately force IDLE, scores 0, bounce 0, serve_dir 1, game_over 0, winner 0, serve counter and contact latches cleared, including mid-match.

Verification
REQ-031 Reset in PLAY with scores 3:2 -> next cycle all outputs at reset values, state IDLE.
REQ-032 start tick, SERVE_FRAMES=2 -> bounce=3 exactly one cycle on the 2nd tick after SERVE entry.
REQ-033 Ball at y=3 for 4 consecutive ticks -> a single bounce=2 pulse; leaves and returns -> a second pulse.
REQ-034 ball_pos_x=630, ball_size_x=8 -> score_player_1 +1, serve_dir=1, re-entry to SERVE; also touching the bottom wall -> goal wins, no bounce=2.
REQ-035 WIN_SCORE=2, two left goals -> score_player_2=2, game_over=1, winner=2; further goals do not change scores.
REQ-036 Ball centre y exactly equal to paddle_2_pos_y+paddle_2_size_y with x overlap -> bounce=1; one pixel below -> bounce=0.
